// File: rtl/arbiter_types.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_types (package)
//  Brief    : Shared types and line/burst geometry for the cache arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package arbiter_types;

    localparam int LINE_W   = 256;
    localparam int BURST_W  = 64;
    localparam int BEATS    = 4;
    localparam int CNT_W    = 2;
    localparam int OFFSET_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        DONE_I  = 3'd4,
        DONE_D  = 3'd5
    } arb_state_t;

    // Drop the byte-within-line offset so memory always sees a line address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adaptor
//  Brief    : Beat counter, read line buffer and write-beat mux that convert
//             between one 256-bit cacheline and four 64-bit memory bursts.
//  Revision : 1.0  initial release
// ============================================================================
module cacheline_adaptor
    import arbiter_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                load_wdata,
    input  logic [LINE_W-1:0]   wdata_i,
    input  logic                beat_valid,
    input  logic                capture,
    input  logic                wr_active,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [LINE_W-1:0]   line_o,
    output logic [BURST_W-1:0]  burst_o,
    output logic                last_beat
);

    logic [CNT_W-1:0]               count_q, count_d;
    logic [BEATS-1:0][BURST_W-1:0]  line_q,  line_d;
    logic [BEATS-1:0][BURST_W-1:0]  wdata_q, wdata_d;

    // Next-state for counter, read buffer and latched write line.
    always_comb begin
        count_d = count_q;
        line_d  = line_q;
        wdata_d = wdata_q;
        if (start) begin
            count_d = '0;
        end
        if (load_wdata) begin
            wdata_d = wdata_i;
        end
        // Read beats land at slice k = count; gaps leave everything untouched.
        if (beat_valid) begin
            if (capture) begin
                line_d[count_q] = burst_i;
            end
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers; the buffer persists until the next read overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            line_q  <= '0;
            wdata_q <= '0;
        end else begin
            count_q <= count_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
        end
    end

    assign line_o    = line_q;
    assign burst_o   = wr_active ? wdata_q[count_q] : '0;
    assign last_beat = beat_valid && (count_q == CNT_W'(BEATS - 1));

endmodule
`default_nettype wire

// File: rtl/p_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : p_cache_arbiter
//  Brief    : Grants one I-cache or D-cache line miss at a time to the burst
//             memory (D-cache first) and returns the line with a resp pulse.
//  Revision : 1.0  initial release
// ============================================================================
module p_cache_arbiter
    import arbiter_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pmem_read,
    input  logic [31:0]         i_pmem_address,
    output logic [LINE_W-1:0]   i_pmem_rdata,
    output logic                i_pmem_resp,
    input  logic                d_pmem_read,
    input  logic                d_pmem_write,
    input  logic [31:0]         d_pmem_address,
    input  logic [LINE_W-1:0]   d_pmem_wdata,
    output logic [LINE_W-1:0]   d_pmem_rdata,
    output logic                d_pmem_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [31:0]         mem_address,
    output logic [BURST_W-1:0]  mem_burst_o,
    input  logic [BURST_W-1:0]  mem_burst_i,
    input  logic                mem_resp
);

    arb_state_t         state_q, state_d;
    logic [31:0]        addr_q,  addr_d;
    logic               start;
    logic               load_wdata;
    logic               beat_valid;
    logic               last_beat;
    logic [LINE_W-1:0]  line;

    // Arbitration, next-state and command/resp outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        start       = 1'b0;
        load_wdata  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // D-cache wins: a D miss stalls the whole pipeline.
                if (d_pmem_write) begin
                    state_d    = D_WRITE;
                    addr_d     = line_align(d_pmem_address);
                    start      = 1'b1;
                    load_wdata = 1'b1;
                end else if (d_pmem_read) begin
                    state_d = D_READ;
                    addr_d  = line_align(d_pmem_address);
                    start   = 1'b1;
                end else if (i_pmem_read) begin
                    state_d = I_READ;
                    addr_d  = line_align(i_pmem_address);
                    start   = 1'b1;
                end
            end
            I_READ: begin
                mem_read = 1'b1;
                if (last_beat) state_d = DONE_I;
            end
            D_READ: begin
                mem_read = 1'b1;
                if (last_beat) state_d = DONE_D;
            end
            D_WRITE: begin
                mem_write = 1'b1;
                if (last_beat) state_d = DONE_D;
            end
            DONE_I: begin
                i_pmem_resp = 1'b1;
                state_d     = IDLE;
            end
            DONE_D: begin
                d_pmem_resp = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched line address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // mem_resp only counts while a command is on the bus.
    assign beat_valid = mem_resp && (mem_read || mem_write);

    cacheline_adaptor u_adaptor (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_wdata (load_wdata),
        .wdata_i    (d_pmem_wdata),
        .beat_valid (beat_valid),
        .capture    (mem_read),
        .wr_active  (mem_write),
        .burst_i    (mem_burst_i),
        .line_o     (line),
        .burst_o    (mem_burst_o),
        .last_beat  (last_beat)
    );

    assign mem_address  = addr_q;
    assign i_pmem_rdata = line;
    assign d_pmem_rdata = line;

endmodule
`default_nettype wire

// File: tb/tb_p_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p_cache_arbiter
//  Brief    : Directed self-checking bench for p_cache_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_p_cache_arbiter;

    logic           clk;
    logic           rst;
    logic           i_pmem_read;
    logic [31:0]    i_pmem_address;
    logic [255:0]   i_pmem_rdata;
    logic           i_pmem_resp;
    logic           d_pmem_read;
    logic           d_pmem_write;
    logic [31:0]    d_pmem_address;
    logic [255:0]   d_pmem_wdata;
    logic [255:0]   d_pmem_rdata;
    logic           d_pmem_resp;
    logic           mem_read;
    logic           mem_write;
    logic [31:0]    mem_address;
    logic [63:0]    mem_burst_o;
    logic [63:0]    mem_burst_i;
    logic           mem_resp;

    int n_cmp;
    int n_err;
    int i_resp_cnt;
    int d_resp_cnt;
    int rd_starts;
    logic prev_rd;

    p_cache_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_burst_o    (mem_burst_o),
        .mem_burst_i    (mem_burst_i),
        .mem_resp       (mem_resp)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count resp pulses and read-command starts, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_rd <= 1'b0;
        end else begin
            prev_rd <= mem_read;
            if (i_pmem_resp) i_resp_cnt <= i_resp_cnt + 1;
            if (d_pmem_resp) d_resp_cnt <= d_resp_cnt + 1;
            if (mem_read && !prev_rd) rd_starts <= rd_starts + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Play the memory side for one transaction; pat bit c = beat in cycle c.
    task automatic serve(input logic is_write, input logic [255:0] line,
                         input logic [15:0] pat, input int plen, input logic [31:0] exp_addr);
        int k;
        k = 0;
        for (int c = 0; c < plen; c++) begin
            if (is_write) chk("cmd_write", {255'd0, mem_write}, 256'd1);
            else          chk("cmd_read",  {255'd0, mem_read},  256'd1);
            chk("mem_address", {224'd0, mem_address}, {224'd0, exp_addr});
            if (pat[c]) begin
                mem_resp    = 1'b1;
                mem_burst_i = line[64*k +: 64];
                if (is_write) chk("burst_o", {192'd0, mem_burst_o}, {192'd0, line[64*k +: 64]});
                k++;
            end else begin
                mem_resp    = 1'b0;
                mem_burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            tick();
        end
        mem_resp    = 1'b0;
        mem_burst_i = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"},  {255'd0, mem_read},    256'd0);
        chk({tag, "_mem_write"}, {255'd0, mem_write},   256'd0);
        chk({tag, "_mem_addr"},  {224'd0, mem_address}, 256'd0);
        chk({tag, "_burst_o"},   {192'd0, mem_burst_o}, 256'd0);
        chk({tag, "_i_rdata"},   i_pmem_rdata,          256'd0);
        chk({tag, "_d_rdata"},   d_pmem_rdata,          256'd0);
        chk({tag, "_i_resp"},    {255'd0, i_pmem_resp}, 256'd0);
        chk({tag, "_d_resp"},    {255'd0, d_pmem_resp}, 256'd0);
    endtask

    logic [255:0] l1, w2, l2, l3, l4, l5a, l5b;
    int d_before, i_before, rd_before;

    initial begin
        n_cmp = 0; n_err = 0;
        i_resp_cnt = 0; d_resp_cnt = 0; rd_starts = 0;
        rst = 1'b1;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_burst_i = '0; mem_resp = 0;

        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        w2  = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
               64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        l2  = {64'h0F0F_0F0F_0000_0004, 64'h0F0F_0F0F_0000_0003,
               64'h0F0F_0F0F_0000_0002, 64'h0F0F_0F0F_0000_0001};
        l3  = {64'h1234_5678_9ABC_DEF3, 64'h1234_5678_9ABC_DEF2,
               64'h1234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF0};
        l4  = {64'hA5A5_A5A5_5A5A_5A5D, 64'hA5A5_A5A5_5A5A_5A5C,
               64'hA5A5_A5A5_5A5A_5A5B, 64'hA5A5_A5A5_5A5A_5A5A};
        l5a = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
               64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
        l5b = {64'h6666_0000_0000_0008, 64'h6666_0000_0000_0007,
               64'h6666_0000_0000_0006, 64'h6666_0000_0000_0005};

        // Reset state.
        tick(); tick(); tick();
        rst = 1'b0;
        chk_all_zero("reset");
        tick();

        // I read alone.
        d_before = d_resp_cnt;
        i_pmem_read = 1; i_pmem_address = 32'h0000_1234;
        tick();
        chk("t1_no_write", {255'd0, mem_write}, 256'd0);
        serve(1'b0, l1, 16'h000F, 4, 32'h0000_1220);
        chk("t1_i_resp", {255'd0, i_pmem_resp}, 256'd1);
        chk("t1_cmd_off", {255'd0, mem_read}, 256'd0);
        chk("t1_i_rdata", i_pmem_rdata, l1);
        i_pmem_read = 0;
        tick();
        chk("t1_resp_one_cycle", {255'd0, i_pmem_resp}, 256'd0);
        chk("t1_rdata_held", i_pmem_rdata, l1);
        chk("t1_no_d_resp", d_resp_cnt, d_before);

        // Simultaneous I read and D write: write first.
        d_pmem_write = 1; d_pmem_address = 32'h0000_805F; d_pmem_wdata = w2;
        i_pmem_read = 1;  i_pmem_address = 32'h0000_2004;
        tick();
        chk("t2_no_read", {255'd0, mem_read}, 256'd0);
        d_pmem_wdata = '1;
        serve(1'b1, w2, 16'h000F, 4, 32'h0000_8040);
        chk("t2_d_resp", {255'd0, d_pmem_resp}, 256'd1);
        chk("t2_i_resp_low", {255'd0, i_pmem_resp}, 256'd0);
        chk("t2_write_off", {255'd0, mem_write}, 256'd0);
        d_pmem_write = 0;
        tick();
        chk("t2_idle_gap", {255'd0, mem_read}, 256'd0);
        tick();
        serve(1'b0, l2, 16'h000F, 4, 32'h0000_2000);
        chk("t2_i_resp", {255'd0, i_pmem_resp}, 256'd1);
        chk("t2_i_rdata", i_pmem_rdata, l2);
        i_pmem_read = 0;
        tick();

        // Gapped beats on a D read.
        d_pmem_read = 1; d_pmem_address = 32'h0000_0100;
        tick();
        serve(1'b0, l3, 16'b000_0000_0101_1001, 7, 32'h0000_0100);
        chk("t3_d_resp", {255'd0, d_pmem_resp}, 256'd1);
        chk("t3_d_rdata", d_pmem_rdata, l3);
        chk("t3_i_rdata_shared", i_pmem_rdata, l3);
        d_pmem_read = 0;
        tick();
        chk("t3_resp_one_cycle", {255'd0, d_pmem_resp}, 256'd0);

        // Reset after beat 2 of a D read.
        d_before = d_resp_cnt;
        d_pmem_read = 1; d_pmem_address = 32'h0000_0300;
        tick();
        serve(1'b0, l3, 16'h0003, 2, 32'h0000_0300);
        rst = 1; d_pmem_read = 0;
        tick();
        chk_all_zero("t4_rst");
        rst = 0;
        tick();
        tick();
        chk("t4_no_d_resp", d_resp_cnt, d_before);
        i_pmem_read = 1; i_pmem_address = 32'h0000_ABCD;
        tick();
        serve(1'b0, l4, 16'h000F, 4, 32'h0000_ABC0);
        chk("t4_i_resp", {255'd0, i_pmem_resp}, 256'd1);
        chk("t4_i_rdata", i_pmem_rdata, l4);
        i_pmem_read = 0;
        tick();

        // Back-to-back I misses.
        i_before = i_resp_cnt; rd_before = rd_starts;
        i_pmem_read = 1; i_pmem_address = 32'h0001_0000;
        tick();
        serve(1'b0, l5a, 16'h000F, 4, 32'h0001_0000);
        chk("t5_resp_a", {255'd0, i_pmem_resp}, 256'd1);
        chk("t5_rdata_a", i_pmem_rdata, l5a);
        i_pmem_read = 0;
        tick();
        chk("t5_idle", {255'd0, mem_read}, 256'd0);
        i_pmem_read = 1; i_pmem_address = 32'h0002_0020;
        tick();
        serve(1'b0, l5b, 16'h000F, 4, 32'h0002_0020);
        chk("t5_resp_b", {255'd0, i_pmem_resp}, 256'd1);
        chk("t5_rdata_b", i_pmem_rdata, l5b);
        i_pmem_read = 0;
        tick(); tick(); tick();
        chk("t5_no_dup", {255'd0, mem_read}, 256'd0);
        chk("t5_resp_count", i_resp_cnt - i_before, 2);
        chk("t5_grant_count", rd_starts - rd_before, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
